// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared types, widths and gap-score helper for the NW fill controller
// Contents: state_t (fill controller state encoding), SCORE_W (score width),
// gap_score(k, gap) = -(k*gap) computed in 32 bits and truncated to SCORE_W bits.
package nw_pkg;

    localparam int SCORE_W = 9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT_ROW = 3'd1,
        S_INIT_COL = 3'd2,
        S_REQ      = 3'd3,
        S_WAIT     = 3'd4,
        S_WR       = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // The product is formed wide so k*gap = 256 wraps to 9'h100 rather than
    // overflowing before negation.
    function automatic logic [SCORE_W-1:0] gap_score(input int k, input int gap);
        logic [31:0] neg;
        neg = 32'(-(k * gap));
        return neg[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/nw_fill_controller_if.sv
// rtl/nw_fill_controller_if.sv - control/init/cell-write bundle of the NW fill controller
// master: the controller (drives strobes, indices, status; receives start/calc_valid).
// slave : the surrounding logic (drives start/calc_valid; receives everything else).
interface nw_fill_controller_if #(
    parameter int BitAddr = 7
);
    import nw_pkg::*;

    logic                 start;
    logic                 calc_valid;
    logic                 en_init;
    logic                 hit;
    logic [BitAddr:0]     addr_init;
    logic [SCORE_W-1:0]   data_init;
    logic                 en_ins;
    logic [BitAddr:0]     i;
    logic [BitAddr:0]     j;
    logic                 calc_req;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, calc_valid,
        output en_init, hit, addr_init, data_init, en_ins, i, j, calc_req, busy, done
    );

    modport slave (
        output start, calc_valid,
        input  en_init, hit, addr_init, data_init, en_ins, i, j, calc_req, busy, done
    );

endinterface

// File: rtl/nw_cell_counter.sv
// rtl/nw_cell_counter.sv - row-major (i,j) cell counter over an N x N grid
// Ports: clk, rst (async, active-high); clear -> i=j=0; advance -> next cell
// in row-major order; i, j current cell; last_cell high at (N-1, N-1).
module nw_cell_counter #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic             last_cell
);

    localparam logic [BitAddr:0] LAST = (BitAddr+1)'(N - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i <= '0;
            j <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
        end else if (advance) begin
            if (j == LAST) begin
                j <= '0;
                i <= i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

    assign last_cell = (i == LAST) && (j == LAST);

endmodule

// File: rtl/nw_fill_controller.sv
// rtl/nw_fill_controller.sv - score-matrix fill sequencer for the Needleman-Wunsch array
// Ports: clk, rst (async, active-high), bus (nw_fill_controller_if.master):
//   start/calc_valid in; en_init/hit/addr_init/data_init init writes;
//   calc_req/en_ins/i/j per-cell compute and write; busy/done status.
module nw_fill_controller
    import nw_pkg::*;
#(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N),
    parameter int GAP     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    nw_fill_controller_if.master  bus
);

    localparam logic [BitAddr:0] K_LAST = (BitAddr+1)'(N);

    state_t             state;
    logic [BitAddr:0]   k;
    logic               en_init_q;
    logic               hit_q;
    logic [BitAddr:0]   addr_init_q;
    logic [SCORE_W-1:0] data_init_q;
    logic               en_ins_q;
    logic               calc_req_q;
    logic               busy_q;
    logic               done_q;

    logic               cnt_clear;
    logic               cnt_advance;
    logic               last_cell;
    logic [BitAddr:0]   cell_i;
    logic [BitAddr:0]   cell_j;

    // The counter steps as WR is left so i/j still name the written cell
    // during en_ins; the last cell is left alone and cleared out of DONE.
    assign cnt_advance = (state == S_WR) && !last_cell;
    assign cnt_clear   = (state == S_DONE);

    nw_cell_counter #(
        .N       (N),
        .BitAddr (BitAddr)
    ) u_cell_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .advance   (cnt_advance),
        .i         (cell_i),
        .j         (cell_j),
        .last_cell (last_cell)
    );

    // Outputs are registered together with the state: each branch loads the
    // values belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            en_init_q   <= 1'b0;
            hit_q       <= 1'b0;
            addr_init_q <= '0;
            data_init_q <= '0;
            en_ins_q    <= 1'b0;
            calc_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            en_init_q   <= 1'b0;
            hit_q       <= 1'b0;
            addr_init_q <= '0;
            data_init_q <= '0;
            en_ins_q    <= 1'b0;
            calc_req_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_INIT_ROW;
                        k           <= '0;
                        en_init_q   <= 1'b1;
                        data_init_q <= gap_score(0, GAP);
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_INIT_ROW: begin
                    en_init_q <= 1'b1;
                    if (k == K_LAST) begin
                        // Column init starts at k=1: (0,0) was written by the row pass.
                        state       <= S_INIT_COL;
                        k           <= (BitAddr+1)'(1);
                        hit_q       <= 1'b1;
                        addr_init_q <= (BitAddr+1)'(1);
                        data_init_q <= gap_score(1, GAP);
                    end else begin
                        k           <= k + 1'b1;
                        addr_init_q <= k + 1'b1;
                        data_init_q <= gap_score(int'(k) + 1, GAP);
                    end
                end
                S_INIT_COL: begin
                    if (k == K_LAST) begin
                        state      <= S_REQ;
                        k          <= '0;
                        calc_req_q <= 1'b1;
                    end else begin
                        k           <= k + 1'b1;
                        en_init_q   <= 1'b1;
                        hit_q       <= 1'b1;
                        addr_init_q <= k + 1'b1;
                        data_init_q <= gap_score(int'(k) + 1, GAP);
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.calc_valid) begin
                        state    <= S_WR;
                        en_ins_q <= 1'b1;
                    end
                end
                S_WR: begin
                    if (last_cell) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state      <= S_REQ;
                        calc_req_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    k      <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en_init   = en_init_q;
    assign bus.hit       = hit_q;
    assign bus.addr_init = addr_init_q;
    assign bus.data_init = data_init_q;
    assign bus.en_ins    = en_ins_q;
    assign bus.i         = cell_i;
    assign bus.j         = cell_j;
    assign bus.calc_req  = calc_req_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_nw_fill_controller.sv
// tb/tb_nw_fill_controller.sv - self-checking bench for nw_fill_controller (N=4, GAP=1)
module tb_nw_fill_controller;

    localparam int N   = 4;
    localparam int GAP = 1;
    localparam int BA  = $clog2(N);
    localparam int AW  = BA + 1;

    typedef struct packed {
        logic          en_init;
        logic          hit;
        logic [AW-1:0] addr_init;
        logic [8:0]    data_init;
        logic          en_ins;
        logic [AW-1:0] i;
        logic [AW-1:0] j;
        logic          calc_req;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   cv;
        bit   st;
        bit   w;
    } exp_t;

    logic clk;
    logic rst;

    nw_fill_controller_if #(.BitAddr(BA)) bus ();

    nw_fill_controller #(
        .N       (N),
        .BitAddr (BA),
        .GAP     (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t cur;
    int   lat[N*N];
    int   cyc = 0;
    int   start_cyc = 0;
    int   done_dist = -1;
    int   req_cnt = 0;
    int   ins_cnt = 0;
    int   done_cnt = 0;

    function automatic logic [8:0] score9(input int k);
        int          v;
        logic [31:0] u;
        v = -(k * GAP);
        u = v;
        return u[8:0];
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.en_init   = bus.en_init;
        a.hit       = bus.hit;
        a.addr_init = bus.addr_init;
        a.data_init = bus.data_init;
        a.en_ins    = bus.en_ins;
        a.i         = bus.i;
        a.j         = bus.j;
        a.calc_req  = bus.calc_req;
        a.busy      = bus.busy;
        a.done      = bus.done;
        return a;
    endfunction

    task automatic check_val(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    task automatic push(input obs_t o, input bit cv, input bit st, input bit w);
        exp_t e;
        e.o  = o;
        e.cv = cv;
        e.st = st;
        e.w  = w;
        q.push_back(e);
    endtask

    function automatic bit rnd(input bit noisy);
        return noisy ? bit'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Expected per-cycle picture of one whole fill, derived from the
    // sequencing rules: one idle start cycle, row pass, column pass, then
    // REQ / lat WAIT cycles / WR per cell, then DONE. The cv/st fields are
    // the inputs the bench drives during that cycle.
    task automatic build_run(input bit noisy);
        obs_t o;
        o = '0;
        push(o, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k <= N; k++) begin
            o = '0;
            o.en_init   = 1'b1;
            o.addr_init = AW'(k);
            o.data_init = score9(k);
            o.busy      = 1'b1;
            push(o, noisy, rnd(noisy), 1'b0);
        end
        for (int k = 1; k <= N; k++) begin
            o = '0;
            o.en_init   = 1'b1;
            o.hit       = 1'b1;
            o.addr_init = AW'(k);
            o.data_init = score9(k);
            o.busy      = 1'b1;
            push(o, rnd(noisy), noisy, 1'b0);
        end
        for (int ci = 0; ci < N; ci++) begin
            for (int cj = 0; cj < N; cj++) begin
                o = '0;
                o.i        = AW'(ci);
                o.j        = AW'(cj);
                o.busy     = 1'b1;
                o.calc_req = 1'b1;
                push(o, noisy, rnd(noisy), 1'b0);
                o.calc_req = 1'b0;
                for (int w = 1; w <= lat[ci*N+cj]; w++)
                    push(o, (w == lat[ci*N+cj]), rnd(noisy), 1'b1);
                o.en_ins = 1'b1;
                push(o, rnd(noisy), rnd(noisy), 1'b0);
            end
        end
        o = '0;
        o.i    = AW'(N - 1);
        o.j    = AW'(N - 1);
        o.busy = 1'b1;
        o.done = 1'b1;
        push(o, rnd(noisy), 1'b0, 1'b0);
    endtask

    task automatic step();
        exp_t e;
        obs_t a;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
        end else begin
            e.o  = '0;
            e.cv = 1'b0;
            e.st = 1'b0;
            e.w  = 1'b0;
        end
        a = sample();
        checks++;
        if (a !== e.o) begin
            errors++;
            if (errors <= 20)
                $display("FAIL outputs cyc=%0d: got en_init=%b hit=%b addr=%0d data=%h en_ins=%b i=%0d j=%0d req=%b busy=%b done=%b, expected en_init=%b hit=%b addr=%0d data=%h en_ins=%b i=%0d j=%0d req=%b busy=%b done=%b",
                         cyc, a.en_init, a.hit, a.addr_init, a.data_init, a.en_ins, a.i, a.j, a.calc_req, a.busy, a.done,
                         e.o.en_init, e.o.hit, e.o.addr_init, e.o.data_init, e.o.en_ins, e.o.i, e.o.j, e.o.calc_req, e.o.busy, e.o.done);
        end
        checks++;
        if (((a.en_init & a.en_ins) | (a.calc_req & a.en_ins)) !== 1'b0) begin
            errors++;
            $display("FAIL strobe_exclusive cyc=%0d: got en_init=%b calc_req=%b en_ins=%b, expected no overlap",
                     cyc, a.en_init, a.calc_req, a.en_ins);
        end
        if (a.calc_req === 1'b1) req_cnt++;
        if (a.en_ins === 1'b1)   ins_cnt++;
        if (a.done === 1'b1) begin
            done_cnt++;
            done_dist = cyc - start_cyc;
        end
        if (e.st && !e.o.busy) start_cyc = cyc;
        bus.calc_valid = e.cv;
        bus.start      = e.st;
        cur = e;
        cyc++;
    endtask

    task automatic do_run(input string tag, input bit noisy);
        int total;
        total = 2*N + 1 + 1;
        for (int c = 0; c < N*N; c++) total += 2 + lat[c];
        req_cnt   = 0;
        ins_cnt   = 0;
        done_cnt  = 0;
        done_dist = -1;
        build_run(noisy);
        while (q.size() > 0) step();
        repeat (3) step();
        check_val({tag, " calc_req pulses"}, req_cnt, N*N);
        check_val({tag, " en_ins pulses"}, ins_cnt, N*N);
        check_val({tag, " done pulses"}, done_cnt, 1);
        check_val({tag, " start-to-done cycles"}, done_dist, total);
    endtask

    initial begin
        obs_t a;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.calc_valid = 1'b0;
        cur.w          = 1'b0;
        cur.o          = '0;
        repeat (2) @(negedge clk);
        a = sample();
        check_val("reset outputs", int'(a), 0);
        rst = 1'b0;
        repeat (2) step();

        // Literal pins on the model and on the package helper.
        check_val("gap_score N=128 GAP=2", int'(nw_pkg::gap_score(128, 2)), 'h100);
        check_val("gap_score k=4 GAP=1", int'(nw_pkg::gap_score(4, 1)), 'h1FC);
        for (int c = 0; c < N*N; c++) lat[c] = 1;
        build_run(1'b0);
        check_val("model row data k=1", int'(q[2].o.data_init), 'h1FF);
        check_val("model row data k=4", int'(q[5].o.data_init), 'h1FC);
        check_val("model col first addr", int'(q[6].o.addr_init), 1);
        check_val("model col first hit", int'(q[6].o.hit), 1);
        check_val("model done index", int'(q[58].o.done), 1);
        check_val("model length", q.size(), 59);
        q.delete();

        // Run 1 and 2: L=1, quiet inputs; second run must match the first.
        do_run("run1", 1'b0);
        check_val("run1 literal total", done_dist, 9 + 48 + 1);
        do_run("run2", 1'b0);
        check_val("run2 literal total", done_dist, 58);

        // Run 3: random latency 1..5, one 20-cycle stall, spurious inputs.
        for (int c = 0; c < N*N; c++) lat[c] = $urandom_range(1, 5);
        lat[5] = 21;
        do_run("run3", 1'b1);

        // Run 4: asynchronous reset in WAIT at cell (2,1).
        for (int c = 0; c < N*N; c++) lat[c] = $urandom_range(2, 4);
        build_run(1'b1);
        for (int n = 0; n < 400 && !(cur.w && cur.o.i == 3'd2 && cur.o.j == 3'd1); n++) step();
        check_val("reached WAIT (2,1)", int'(cur.w && cur.o.i == 3'd2 && cur.o.j == 3'd1), 1);
        bus.calc_valid = 1'b0;
        bus.start      = 1'b0;
        #1 rst = 1'b1;
        #1;
        a = sample();
        check_val("async reset outputs", int'(a), 0);
        check_val("async reset busy", int'(bus.busy), 0);
        #1 rst = 1'b0;
        q.delete();
        cur.w = 1'b0;
        repeat (3) step();

        // Run 5: a fresh start after the reset re-runs from INIT_ROW k=0.
        for (int c = 0; c < N*N; c++) lat[c] = $urandom_range(1, 5);
        do_run("run5", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
